// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: state encodings and per-state reset levels for the reset sequencer
package rst_seq_pkg;

    localparam logic [2:0] ST_RESET    = 3'd0;
    localparam logic [2:0] ST_MEM_HOLD = 3'd1;
    localparam logic [2:0] ST_MEM_CAL  = 3'd2;
    localparam logic [2:0] ST_PERIPH   = 3'd3;
    localparam logic [2:0] ST_CPU      = 3'd4;
    localparam logic [2:0] ST_RUN      = 3'd5;
    localparam logic [2:0] ST_SOFT     = 3'd6;

    // {mem, periph, cpu} reset levels indexed by state; unused encoding holds everything in reset
    localparam logic [2:0] RST_LVL [8] = '{
        3'b111, 3'b111, 3'b011, 3'b011, 3'b001, 3'b000, 3'b011, 3'b111
    };

    function automatic logic [2:0] rst_lvl(input logic [2:0] st);
        return RST_LVL[st];
    endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// sync2: two-flop synchroniser with asynchronous active-high clear
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, sync_q;

    // shift the asynchronous input through two flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// rst_seq: staged reset release for memory, peripherals and CPU with calibration gating and soft reset
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int MEM_DLY      = 256,
    parameter int CAL_TIMEOUT  = 65535,
    parameter int PERIPH_DLY   = 64,
    parameter int CPU_DLY      = 64,
    parameter int SOFT_RST_LEN = 16
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       mem_calib_done_i,
    input  logic       soft_rst_req_i,
    output logic       soft_rst_ack_o,
    output logic       mem_rst_o,
    output logic       periph_rst_o,
    output logic       cpu_rst_o,
    output logic       cal_timeout_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_DLY - 1);
    localparam logic [CNT_W-1:0] CAL_LAST    = CNT_W'(CAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_DLY - 1);
    localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST   = CNT_W'(SOFT_RST_LEN - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             to_q, to_d;
    logic [2:0]       lvl_q, lvl_d;
    logic             calib_sync;

    sync2 u_calib_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (mem_calib_done_i),
        .q   (calib_sync)
    );

    // state, counter and registered outputs; everything returns to its reset value asynchronously
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
            lvl_q   <= 3'b111;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
            lvl_q   <= lvl_d;
        end
    end

    // next state; calibration wins over a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:    state_d = ST_MEM_HOLD;
            ST_MEM_HOLD: state_d = cnt_q == MEM_LAST ? ST_MEM_CAL : state_q;
            ST_MEM_CAL:  state_d = calib_sync ? ST_PERIPH : cnt_q == CAL_LAST ? ST_MEM_HOLD : state_q;
            ST_PERIPH:   state_d = cnt_q == PERIPH_LAST ? ST_CPU : state_q;
            ST_CPU:      state_d = cnt_q == CPU_LAST ? ST_RUN : state_q;
            ST_RUN:      state_d = soft_rst_req_i && !ack_q ? ST_SOFT : state_q;
            ST_SOFT:     state_d = cnt_q == SOFT_LAST ? ST_PERIPH : state_q;
            default:     state_d = ST_RESET;
        endcase
    end

    // counter, handshake, sticky timeout and reset levels derived from the next state so they move with state_o
    always_comb begin
        cnt_d = (state_d != state_q || state_q == ST_RESET || state_q == ST_RUN) ? '0 : cnt_q + 1'b1;
        ack_d = (state_q == ST_RUN && state_d == ST_SOFT) ? 1'b1 : ack_q && soft_rst_req_i;
        to_d  = to_q || (state_q == ST_MEM_CAL && state_d == ST_MEM_HOLD);
        lvl_d = rst_lvl(state_d);
    end

    assign {mem_rst_o, periph_rst_o, cpu_rst_o} = lvl_q;
    assign soft_rst_ack_o = ack_q;
    assign cal_timeout_o  = to_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and random checks of rst_seq against a countdown-based reference model
module tb_rst_seq;

    localparam int MEM_DLY      = 8;
    localparam int CAL_TIMEOUT  = 32;
    localparam int PERIPH_DLY   = 4;
    localparam int CPU_DLY      = 4;
    localparam int SOFT_RST_LEN = 3;

    logic       clk = 0, rst = 0, calib = 0, req = 0;
    logic       ack, mem, per, cpu, to;
    logic [2:0] st;
    int         checks = 0, errors = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_v;
    logic [2:0] m_st = 0;
    int         m_rem = 0;
    logic       m_ack = 0, m_to = 0, m_s1 = 0, m_s2 = 0, m_a = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .CNT_W        (16),
        .MEM_DLY      (MEM_DLY),
        .CAL_TIMEOUT  (CAL_TIMEOUT),
        .PERIPH_DLY   (PERIPH_DLY),
        .CPU_DLY      (CPU_DLY),
        .SOFT_RST_LEN (SOFT_RST_LEN)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .mem_calib_done_i (calib),
        .soft_rst_req_i   (req),
        .soft_rst_ack_o   (ack),
        .mem_rst_o        (mem),
        .periph_rst_o     (per),
        .cpu_rst_o        (cpu),
        .cal_timeout_o    (to),
        .state_o          (st)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs();
        return {st, mem, per, cpu, ack, to};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
    endtask

    // reference model: each timed state is loaded with its delay and left when one cycle remains
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_rem = 0; m_ack = 0; m_to = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_a = m_ack;
            if (m_ack && !req) m_ack = 0;
            case (m_st)
                3'd0: begin m_st = 1; m_rem = MEM_DLY; end
                3'd1: if (m_rem == 1) begin m_st = 2; m_rem = CAL_TIMEOUT; end else m_rem--;
                3'd2: if (m_s2) begin m_st = 3; m_rem = PERIPH_DLY; end
                      else if (m_rem == 1) begin m_st = 1; m_rem = MEM_DLY; m_to = 1; end
                      else m_rem--;
                3'd3: if (m_rem == 1) begin m_st = 4; m_rem = CPU_DLY; end else m_rem--;
                3'd4: if (m_rem == 1) m_st = 5; else m_rem--;
                3'd5: if (req && !m_a) begin m_st = 6; m_rem = SOFT_RST_LEN; m_ack = 1; end
                default: if (m_rem == 1) begin m_st = 3; m_rem = PERIPH_DLY; end else m_rem--;
            endcase
            m_s2 = m_s1;
            m_s1 = calib;
        end
        sb.push_back({m_st, m_st < 3'd2, m_st != 3'd4 && m_st != 3'd5, m_st != 3'd5, m_ack, m_to});
    end

    // compare DUT outputs against the newest model prediction away from the active edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            while (sb.size() > 1) void'(sb.pop_front());
            exp_v = sb.pop_front();
            chk("sb", obs(), exp_v);
        end
    end

    initial begin
        #1 rst = 1;
        calib = 1;
        step(2);
        rst = 0;
        step(1);  chk("e1_hold",   obs(), {3'd1, 5'b11100});
        step(8);  chk("e9_cal",    obs(), {3'd2, 5'b01100});
        step(1);  chk("e10_per",   obs(), {3'd3, 5'b01100});
        step(4);  chk("e14_cpu",   obs(), {3'd4, 5'b00100});
        step(4);  chk("e18_run",   obs(), {3'd5, 5'b00000});
        req = 1;
        step(1);  chk("soft_in",   obs(), {3'd6, 5'b01110});
        step(3);  chk("soft_per",  obs(), {3'd3, 5'b01110});
        step(8);  chk("soft_run",  obs(), {3'd5, 5'b00010});
        step(2);  chk("no_retrig", obs(), {3'd5, 5'b00010});
        req = 0;
        step(1);  chk("ack_clr",   obs(), {3'd5, 5'b00000});
        step(1);  chk("run_stay",  obs(), {3'd5, 5'b00000});
        req = 1;
        step(1);  chk("soft2",     obs(), {3'd6, 5'b01110});
        rst = 1;
        req = 0;
        #1;       chk("arst_soft", obs(), {3'd0, 5'b11100});
        #2 rst = 0;
        step(1);  chk("re_hold",   obs(), {3'd1, 5'b11100});
        step(9);  chk("re_per",    obs(), {3'd3, 5'b01100});
        rst = 1;
        #1;       chk("arst_per",  obs(), {3'd0, 5'b11100});
        #2 rst = 0;
        step(18); chk("re_run",    obs(), {3'd5, 5'b00000});
        calib = 0;
        do_reset();
        step(40); chk("to_pre",    obs(), {3'd2, 5'b01100});
        step(1);  chk("to_hit",    obs(), {3'd1, 5'b11101});
        step(8);  chk("to_cal2",   obs(), {3'd2, 5'b01101});
        step(3);
        calib = 1;
        step(2);  chk("cal2_wait", obs(), {3'd2, 5'b01101});
        step(1);  chk("cal2_per",  obs(), {3'd3, 5'b01101});
        calib = 0;
        do_reset();
        step(38);
        calib = 1;
        step(2);  chk("coin_pre",  obs(), {3'd2, 5'b01100});
        step(1);  chk("coin_per",  obs(), {3'd3, 5'b01100});
        do_reset();
        repeat (3000) begin
            @(negedge clk);
            #1;
            calib = $urandom_range(0, 99) < 4;
            req   = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
